// File: rtl/mips_core.sv
// Single-cycle MIPS32 subset core with an internal program ROM and data RAM.
// Each rising clk edge fetches, executes and commits one instruction.
// Supported: add, sub, and, or, slt, addi, lw, sw, beq, j. Anything else is a NOP.
module mips_core #(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        Reset,
    output logic [31:0] ALUResult
);

    // Memory index widths; indices wrap naturally by truncating the byte address.
    localparam int unsigned IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    // Primary opcodes.
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type function codes.
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    // Architectural state.
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] rf_q   [32];
    logic [31:0] dmem_q [DMEM_WORDS];

    // Fetch / decode fields.
    logic [IAW-1:0] imem_idx;
    logic [31:0]    instr;
    logic [5:0]     opcode;
    logic [5:0]     funct;
    logic [4:0]     rs;
    logic [4:0]     rt;
    logic [4:0]     rd;
    logic [31:0]    imm_sext;
    logic [31:0]    rs_val;
    logic [31:0]    rt_val;
    logic [31:0]    pc_plus4;

    // Execute / commit controls.
    logic [31:0]    alu_res;
    logic           reg_we;
    logic [4:0]     reg_waddr;
    logic           is_load;
    logic           mem_we;
    logic [DAW-1:0] dmem_idx;
    logic [31:0]    mem_rdata;
    logic [31:0]    reg_wdata;

    assign imem_idx = pc_q[IAW+1:2];

    // Program ROM: words 0-11 hold the fixed program, everything else reads as zero (NOP).
    always_comb begin
        instr = 32'h0000_0000;
        case (int'(imem_idx))
            0:       instr = 32'h2001_0005; // addi $1,$0,5
            1:       instr = 32'h2002_0003; // addi $2,$0,3
            2:       instr = 32'h0022_1820; // add  $3,$1,$2
            3:       instr = 32'h0022_2022; // sub  $4,$1,$2
            4:       instr = 32'h0022_2824; // and  $5,$1,$2
            5:       instr = 32'h0022_3025; // or   $6,$1,$2
            6:       instr = 32'h0041_382A; // slt  $7,$2,$1
            7:       instr = 32'hAC03_0004; // sw   $3,4($0)
            8:       instr = 32'h8C08_0004; // lw   $8,4($0)
            9:       instr = 32'h1103_0001; // beq  $8,$3,+1
            10:      instr = 32'h2009_0001; // addi $9,$0,1
            11:      instr = 32'h0800_000B; // j    11
            default: instr = 32'h0000_0000;
        endcase
    end

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign pc_plus4 = pc_q + 32'd4;

    // $0 is hardwired to zero on the read side as well as never being written.
    assign rs_val = (rs == 5'd0) ? 32'h0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? 32'h0 : rf_q[rt];

    // Decode and execute: ALU result, writeback controls and next PC.
    always_comb begin
        alu_res   = 32'h0;
        reg_we    = 1'b0;
        reg_waddr = 5'd0;
        is_load   = 1'b0;
        mem_we    = 1'b0;
        pc_d      = pc_plus4;
        case (opcode)
            OpRtype: begin
                case (funct)
                    FnAdd: begin
                        alu_res   = rs_val + rt_val;
                        reg_we    = 1'b1;
                        reg_waddr = rd;
                    end
                    FnSub: begin
                        alu_res   = rs_val - rt_val;
                        reg_we    = 1'b1;
                        reg_waddr = rd;
                    end
                    FnAnd: begin
                        alu_res   = rs_val & rt_val;
                        reg_we    = 1'b1;
                        reg_waddr = rd;
                    end
                    FnOr: begin
                        alu_res   = rs_val | rt_val;
                        reg_we    = 1'b1;
                        reg_waddr = rd;
                    end
                    FnSlt: begin
                        alu_res   = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
                        reg_we    = 1'b1;
                        reg_waddr = rd;
                    end
                    default: begin
                        // Unknown funct (including the all-zero word) is a NOP.
                        alu_res = 32'h0;
                    end
                endcase
            end
            OpAddi: begin
                alu_res   = rs_val + imm_sext;
                reg_we    = 1'b1;
                reg_waddr = rt;
            end
            OpLw: begin
                alu_res   = rs_val + imm_sext;
                reg_we    = 1'b1;
                reg_waddr = rt;
                is_load   = 1'b1;
            end
            OpSw: begin
                alu_res = rs_val + imm_sext;
                mem_we  = 1'b1;
            end
            OpBeq: begin
                alu_res = rs_val - rt_val;
                if (rs_val == rt_val) begin
                    pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
                end
            end
            OpJ: begin
                alu_res = 32'h0;
                pc_d    = {pc_plus4[31:28], instr[25:0], 2'b00};
            end
            default: begin
                alu_res = 32'h0;
            end
        endcase
    end

    assign dmem_idx  = alu_res[DAW+1:2];
    assign mem_rdata = dmem_q[dmem_idx];
    assign reg_wdata = is_load ? mem_rdata : alu_res;

    // The visible result is held at zero for as long as reset is asserted.
    assign ALUResult = Reset ? alu_res : 32'h0;

    // Program counter: reset to word 0, otherwise advance to the computed next PC.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            pc_q <= 32'h0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Register file: reset clears every register and overrides any pending write.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else if (reg_we && (reg_waddr != 5'd0)) begin
            rf_q[reg_waddr] <= reg_wdata;
        end
    end

    // Data RAM: reset clears every word and overrides a pending store.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            for (int i = 0; i < int'(DMEM_WORDS); i++) begin
                dmem_q[i] <= 32'h0;
            end
        end else if (mem_we) begin
            dmem_q[dmem_idx] <= rt_val;
        end
    end

endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: reset behaviour, the fixed program, the self-loop
// and a mid-program reset followed by an identical replay.
module tb_mips_core;

    logic        clk;
    logic        Reset;
    logic [31:0] ALUResult;

    int total;
    int bad;

    mips_core #(
        .IMEM_WORDS(64),
        .DMEM_WORDS(64)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .ALUResult(ALUResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // OR of every register and every RAM word; zero when the state is fully cleared.
    task automatic chk_cleared(input string tag);
        logic [31:0] acc_rf;
        logic [31:0] acc_dm;
        acc_rf = 32'h0;
        acc_dm = 32'h0;
        for (int i = 0; i < 32; i++) acc_rf = acc_rf | dut.rf_q[i];
        for (int i = 0; i < 64; i++) acc_dm = acc_dm | dut.dmem_q[i];
        chk({tag, "_pc"}, dut.pc_q, 32'h0);
        chk({tag, "_rf_or"}, acc_rf, 32'h0);
        chk({tag, "_dmem_or"}, acc_dm, 32'h0);
    endtask

    // Runs the program from PC 0; entered just after reset release, off the clock edge.
    task automatic run_program(input string tag);
        logic [31:0] exp_alu [10];
        logic [31:0] exp_reg [10];
        exp_alu = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7, 32'd1, 32'd4, 32'd4, 32'd0};
        // Expected $0..$9 after the branch commits.
        exp_reg = '{32'd0, 32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7, 32'd1, 32'd8, 32'd0};
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s_pc_w%0d", tag, i), dut.pc_q, 32'(i * 4));
            chk($sformatf("%s_alu_w%0d", tag, i), ALUResult, exp_alu[i]);
            @(negedge clk);
        end
        // beq taken: word 10 skipped.
        chk({tag, "_pc_after_beq"}, dut.pc_q, 32'd44);
        for (int r = 0; r < 10; r++) begin
            chk($sformatf("%s_reg%0d", tag, r), dut.rf_q[r], exp_reg[r]);
        end
        chk({tag, "_ram_w1"}, dut.dmem_q[1], 32'd8);
        chk({tag, "_ram_w0"}, dut.dmem_q[0], 32'd0);
        // Self-loop on j 11.
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s_loop_alu%0d", tag, c), ALUResult, 32'd0);
            @(negedge clk);
            chk($sformatf("%s_loop_pc%0d", tag, c), dut.pc_q, 32'd44);
            chk($sformatf("%s_loop_r9_%0d", tag, c), dut.rf_q[9], 32'd0);
            chk($sformatf("%s_loop_r3_%0d", tag, c), dut.rf_q[3], 32'd8);
            chk($sformatf("%s_loop_ram_%0d", tag, c), dut.dmem_q[1], 32'd8);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b0;

        // Reset held low across the first edges.
        @(negedge clk);
        chk("rst_alu_low", ALUResult, 32'h0);
        @(negedge clk);
        chk("rst_alu_low2", ALUResult, 32'h0);
        chk_cleared("rst_state");

        // Release and run the program.
        Reset = 1'b1;
        #1;
        run_program("run1");

        // One-edge reset pulse during the self-loop.
        Reset = 1'b0;
        #1;
        chk("mid_rst_alu_low", ALUResult, 32'h0);
        @(negedge clk);
        chk_cleared("mid_rst_state");
        chk("mid_rst_r8", dut.rf_q[8], 32'h0);
        Reset = 1'b1;
        #1;
        run_program("run2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_core.md
MIPS_CORE -- requirements
Module: mips_core

Interface
REQ-001 Parameter IMEM_WORDS, default 64: instruction ROM depth in 32-bit words, word-indexed by PC[7:2].
REQ-002 Parameter DMEM_WORDS, default 64: data RAM depth in 32-bit words, word-indexed by address[7:2].
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port Reset  input  1  reset, synchronous, active-low.
REQ-005 Port ALUResult  output  32  combinational ALU result of the instruction currently addressed by PC.
REQ-006 The block SHALL have one clock; reset is synchronous and active-low.

Function
REQ-007 The block SHALL be a single-cycle MIPS32 subset core: one instruction fetched, executed and committed per rising clk edge.
REQ-008 Internal state SHALL be:
- 32-bit PC
- 32x32 register file, $0 reads 0 and ignores writes
- instruction ROM (IMEM_WORDS)
- data RAM (DMEM_WORDS)
REQ-009 Supported instructions SHALL be:
- R-type op 0x00: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A
- addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02
REQ-010 Any other opcode/funct, including word 0x00000000, SHALL be a NOP: no register or memory write, PC+4, ALUResult 0.
REQ-011 ALU operations:
- add/sub/and/or wrap modulo 2^32; overflow ignored, no exception
- slt is a signed compare yielding 1 or 0
REQ-012 Per-instruction ALU operands:
- I-type immediates are sign-extended
- addi, lw, sw: ALUResult = rs + imm
- beq: ALUResult = rs - rt
- j: ALUResult = 0
REQ-013 Register writes SHALL occur at the rising edge:
- R-type writes rd
- addi and lw write rt
- lw data = RAM[ALUResult[7:2]]
REQ-014 sw SHALL write rt to RAM[ALUResult[7:2]] at the rising edge; reads are combinational (asynchronous).
REQ-015 Next PC SHALL be:
- PC+4 by default
- beq with rs==rt: PC+4+(sign-extended imm<<2)
- j: {PC+4[31:28], target26, 2'b00}
REQ-016 Memory address indices SHALL wrap modulo depth; no out-of-range fault.
REQ-017 The ROM SHALL hold the following program at words 0-11, all other words 0:
- addi $1,$0,5; addi $2,$0,3
- add $3,$1,$2; sub $4,$1,$2; and $5,$1,$2; or $6,$1,$2; slt $7,$2,$1
- sw $3,4($0); lw $8,4($0)
- beq $8,$3,+1; addi $9,$0,1
- j 11 (self-loop)

Reset
REQ-018 A rising edge with Reset=0 SHALL set PC=0 and clear all registers and all data RAM words to 0.
REQ-019 While Reset=0, ALUResult SHALL be driven to 0.
REQ-020 Reset SHALL take precedence over any write of the current instruction.
REQ-021 Reset asserted mid-program SHALL restart execution from word 0 on the first edge with Reset=1.

Verification
REQ-022 Reset low for one edge, then high -> ALUResult 0 while low; first cycle after release ALUResult=5, then 3.
REQ-023 Words 2-6 execute -> ALUResult sequence 8, 2, 1, 7, 1; $3..$7 = 8, 2, 1, 7, 1.
REQ-024 sw then lw -> both cycles ALUResult=4; RAM word 1 = 8; $8 = 8.
REQ-025 beq cycle -> ALUResult=0, branch taken, word 10 skipped, $9 stays 0; next PC = 44.
REQ-026 j 11 -> PC stays 44 indefinitely, ALUResult=0, no state changes.
REQ-027 Reset pulsed low for one edge during the self-loop -> PC=0, registers/RAM cleared, program replays identically.
